digi_readout: RTL
=================

DIGI_READOUT -- requirements
Module: digi_readout

Interface
REQ-001 Parameter SIZE, default 8, width of sample count and ring-buffer address.
REQ-002 Parameter WIDTH, default 16, sample/output word width; SHALL satisfy WIDTH >= SIZE+4.
REQ-003 Parameter LAT, default 2, cycles from a cycle with rd_request high to the matching sample valid on din.
REQ-004 CK50  input  1  sole clock; all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to read out one event.
REQ-007 howmany_cfg  input  SIZE  number of samples per event.
REQ-008 offset_cfg  input  SIZE  start offset within the channel ring buffer.
REQ-009 din  input  WIDTH  sample data returned by the digitizer channel.
REQ-010 out_ready  input  1  downstream accepts a word.
REQ-011 rd_request  output  1  readout strobe to the digitizer channel.
REQ-012 howmany  output  SIZE  latched sample count presented to the channel.
REQ-013 offset  output  SIZE  latched offset presented to the channel.
REQ-014 out_data  output  WIDTH  frame word.
REQ-015 out_valid  output  1  out_data valid.
REQ-016 out_last  output  1  out_data is the frame trailer.
REQ-017 busy  output  1  frame in progress (accept to trailer popped).
REQ-018 evt_count  output  WIDTH-4  completed-frame counter.

Function
REQ-019 FSM states SHALL be IDLE, HEADER, REQ, DRAIN, TRAILER.
REQ-020 start SHALL be accepted only in IDLE with internal FIFO empty; otherwise ignored, no side effect.
REQ-021 On accept (cycle 0): latch howmany_cfg/offset_cfg into howmany/offset, busy=1, go HEADER; latched values stable until next accept.
REQ-022 HEADER (cycle 1): write {4'hA, evt_count} to FIFO; go REQ if howmany!=0, else TRAILER.
REQ-023 REQ: rd_request=1 for exactly howmany consecutive cycles (cycles 2..howmany+1), then DRAIN.
REQ-024 Capture: din written to FIFO on each cycle that is LAT cycles after a rd_request-high cycle; exactly howmany samples, in order.
REQ-025 DRAIN: wait until last sample captured (cycle howmany+1+LAT), then TRAILER.
REQ-026 TRAILER: write {4'hE, zero-extended howmany} with last flag to FIFO; evt_count increments by 1 (wraps modulo 2^(WIDTH-4)); go IDLE.
REQ-027 howmany=0: no rd_request pulse; frame is header plus trailer only.
REQ-028 FIFO: depth 2^SIZE+2, WIDTH+1 bits (data + last); first-word-fall-through.
REQ-029 out_valid = FIFO not empty; word popped when out_valid && out_ready; out_last = stored flag of head word.
REQ-030 Capture SHALL NOT stall on out_ready low; no overflow possible by REQ-020 and REQ-028.
REQ-031 busy SHALL drop the cycle after the trailer is popped.

Reset
REQ-032 RST high SHALL asynchronously force IDLE, FIFO empty, rd_request=0, out_valid=0, out_last=0, busy=0, howmany=0, offset=0, evt_count=0, out_data=0.
REQ-033 Reset mid-frame SHALL discard partial frame; no trailer emitted; first frame after reset carries evt_count 0.

Verification
REQ-034 howmany_cfg=4, offset_cfg=8, out_ready=1, start at c0 -> rd_request high c2..c5; out frame A000, 4 samples in order, E004 with out_last; evt_count=1.
REQ-035 howmany_cfg=0, start -> no rd_request; frame A000, E000 (out_last=1); busy low after trailer pop.
REQ-036 howmany_cfg=255, out_ready=0 throughout capture -> all 257 words held; releasing out_ready yields complete frame, no loss.
REQ-037 start pulsed while busy and again with FIFO non-empty in IDLE -> ignored; exactly one frame output.
REQ-038 RST asserted during REQ -> rd_request, out_valid, busy low immediately; next frame header A000.
REQ-039 Back-to-back frames, 4096 events -> evt_count in header wraps 0xFFF to 0x000.

Source files
------------

// File: rtl/digi_readout.sv
// digi_readout: reads one event out of a digitizer channel and frames it.
//
// On an accepted start the block latches the sample count and ring-buffer
// offset and queues a header word. It then strobes rd_request once per sample
// and captures the data the channel returns LAT cycles after each strobe.
// Finally it queues a trailer word that carries the last flag. All words pass
// through a first-word-fall-through FIFO, so capture never stalls on the
// downstream side.
//
// Ports:
//   CK50        in   clock, rising edge
//   RST         in   asynchronous active-high reset
//   start       in   one-cycle readout request (accepted only when idle and drained)
//   howmany_cfg in   samples per event
//   offset_cfg  in   start offset in the channel ring buffer
//   din         in   sample data from the channel
//   out_ready   in   downstream accepts the head word
//   rd_request  out  readout strobe to the channel
//   howmany     out  latched sample count
//   offset      out  latched offset
//   out_data    out  head frame word (zero when empty)
//   out_valid   out  head word valid
//   out_last    out  head word is the trailer
//   busy        out  frame in progress, from accept until the trailer is popped
//   evt_count   out  completed-frame counter
module digi_readout #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 16,
  parameter int LAT   = 2
) (
  input  logic               CK50,
  input  logic               RST,
  input  logic               start,
  input  logic [SIZE-1:0]    howmany_cfg,
  input  logic [SIZE-1:0]    offset_cfg,
  input  logic [WIDTH-1:0]   din,
  input  logic               out_ready,
  output logic               rd_request,
  output logic [SIZE-1:0]    howmany,
  output logic [SIZE-1:0]    offset,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic [WIDTH-5:0]   evt_count
);

  localparam int EW    = WIDTH - 4;
  localparam int DEPTH = (1 << SIZE) + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, HEADER, REQ, DRAIN, TRAILER} state_t;

  state_t           state;
  logic [SIZE-1:0]  req_left;
  logic [SIZE-1:0]  cap_cnt;
  logic [LAT-1:0]   rd_pipe;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             not_empty;

  logic             cap;
  logic             pop;
  logic             accept;
  logic             wr_en;
  logic [WIDTH:0]   wr_word;

  // rd_pipe[LAT-1] marks the cycle in which the channel returns a sample.
  assign cap       = rd_pipe[LAT-1];
  assign pop       = not_empty && out_ready;
  assign accept    = (state == IDLE) && !not_empty && start;
  assign out_valid = not_empty;
  assign out_data  = not_empty ? mem[rd_ptr][WIDTH-1:0] : {WIDTH{1'b0}};
  assign out_last  = not_empty ? mem[rd_ptr][WIDTH] : 1'b0;
  assign count_nxt = count + CW'(wr_en) - CW'(pop);

  // Select the single word written to the FIFO this cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_word = {(WIDTH+1){1'b0}};
    case (state)
      HEADER: begin
        wr_en   = 1'b1;
        wr_word = {1'b0, 4'hA, evt_count};
      end
      TRAILER: begin
        wr_en   = 1'b1;
        wr_word = {1'b1, 4'hE, EW'(howmany)};
      end
      REQ, DRAIN: begin
        if (cap) begin
          wr_en   = 1'b1;
          wr_word = {1'b0, din};
        end else begin
          wr_en   = 1'b0;
          wr_word = {(WIDTH+1){1'b0}};
        end
      end
      default: begin
        wr_en   = 1'b0;
        wr_word = {(WIDTH+1){1'b0}};
      end
    endcase
  end

  // Readout sequencer, capture bookkeeping and frame counters.
  always_ff @(posedge CK50 or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      rd_request <= 1'b0;
      howmany    <= {SIZE{1'b0}};
      offset     <= {SIZE{1'b0}};
      busy       <= 1'b0;
      evt_count  <= {EW{1'b0}};
      req_left   <= {SIZE{1'b0}};
      cap_cnt    <= {SIZE{1'b0}};
      rd_pipe    <= {LAT{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            howmany <= howmany_cfg;
            offset  <= offset_cfg;
            busy    <= 1'b1;
            cap_cnt <= {SIZE{1'b0}};
            state   <= HEADER;
          end
        end
        HEADER: begin
          if (howmany != {SIZE{1'b0}}) begin
            rd_request <= 1'b1;
            req_left   <= howmany;
            state      <= REQ;
          end else begin
            state <= TRAILER;
          end
        end
        REQ: begin
          if (req_left == SIZE'(1)) begin
            rd_request <= 1'b0;
            state      <= DRAIN;
          end else begin
            req_left <= req_left - SIZE'(1);
          end
        end
        DRAIN: begin
          // Every strobe has returned its sample once the capture count matches.
          if (cap_cnt == howmany) begin
            state <= TRAILER;
          end
        end
        TRAILER: begin
          evt_count <= evt_count + EW'(1);
          state     <= IDLE;
        end
        default: begin
          rd_request <= 1'b0;
          state      <= IDLE;
        end
      endcase
      if (cap) begin
        cap_cnt <= cap_cnt + SIZE'(1);
      end
      if (pop && out_last) begin
        busy <= 1'b0;
      end
      rd_pipe <= (rd_pipe << 1) | LAT'(rd_request);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CK50 or posedge RST) begin
    if (RST) begin
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      count     <= {CW{1'b0}};
      not_empty <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      not_empty <= (count_nxt != {CW{1'b0}});
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CK50) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_word;
    end
  end

endmodule
